// File: rtl/load_store_unit_if.sv
// Bundles the pipeline-side request signals and the data-memory bus of the load/store unit.
// The slave modport is the LSU's view; the master modport is the pipeline and memory side.
interface load_store_unit_if;
    logic        mem_read_control;
    logic        mem_write_control;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        access_fault;

    modport slave (
        input  mem_read_control, mem_write_control, funct3, addr, store_data,
        input  dmem_ready, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output stall, load_data, load_valid, access_fault
    );

    modport master (
        output mem_read_control, mem_write_control, funct3, addr, store_data,
        output dmem_ready, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  stall, load_data, load_valid, access_fault
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: classifies an access, runs a single request/ready handshake
// with a bounded wait, and returns lane-aligned store data or an extended load result.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        if (we) begin
            bad = (f3 > 3'd2);
        end else begin
            bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        end
        return bad;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] strb;
        case (f3[1:0])
            2'b00:   strb = 4'b0001 << off;
            2'b01:   strb = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] lanes;
        case (f3[1:0])
            2'b00:   lanes = {4{data[7:0]}};
            2'b01:   lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        logic [31:0] res;
        byte_sh = word >> {off, 3'b000};
        half_sh = word >> {off[1], 4'b0000};
        case (f3)
            3'b000:  res = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b001:  res = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b010:  res = word;
            3'b100:  res = {24'd0, byte_sh[7:0]};
            3'b101:  res = {16'd0, half_sh[15:0]};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] sdata_q, sdata_d;
    logic        we_q, we_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        fault_q, fault_d;

    logic        new_we_s;
    logic        new_bad_s;
    logic        stall_s;
    logic        in_req_s;
    logic [3:0]  cnt_inc_s;

    assign new_we_s  = bus.mem_write_control;
    assign new_bad_s = is_illegal(new_we_s, bus.funct3) || is_misaligned(bus.funct3, bus.addr[1:0]);
    assign cnt_inc_s = cnt_q + 4'd1;

    // Next-state, capture and pulse logic for the access sequencer.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        sdata_d      = sdata_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        fault_d      = 1'b0;
        stall_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_write_control || bus.mem_read_control) begin
                    if (new_bad_s) begin
                        fault_d = 1'b1;
                    end else begin
                        stall_s  = 1'b1;
                        addr_d   = bus.addr;
                        funct3_d = bus.funct3;
                        sdata_d  = bus.store_data;
                        we_d     = new_we_s;
                        cnt_d    = 4'd0;
                        state_d  = REQ;
                    end
                end else begin
                    stall_s = 1'b0;
                end
            end
            REQ: begin
                stall_s = 1'b1;
                if (bus.dmem_ready) begin
                    state_d = DONE;
                    if (!we_q) begin
                        load_data_d  = extract_load(funct3_q, addr_q[1:0], bus.dmem_rdata);
                        load_valid_d = 1'b1;
                    end else begin
                        load_valid_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_inc_s;
                    // Give up once TIMEOUT request cycles have gone unanswered.
                    if (cnt_inc_s == TIMEOUT_C) begin
                        fault_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= 32'd0;
            funct3_q     <= 3'd0;
            sdata_q      <= 32'd0;
            we_q         <= 1'b0;
            cnt_q        <= 4'd0;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            sdata_q      <= sdata_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            fault_q      <= fault_d;
        end
    end

    // Memory bus is driven only from captured values so it stays stable until ready.
    assign in_req_s         = (state_q == REQ) && !rst;
    assign bus.dmem_req     = in_req_s;
    assign bus.dmem_we      = in_req_s && we_q;
    assign bus.dmem_addr    = {addr_q[31:2], 2'b00};
    assign bus.dmem_wdata   = store_lanes(funct3_q, sdata_q);
    assign bus.dmem_wstrb   = (in_req_s && we_q) ? store_strb(funct3_q, addr_q[1:0]) : 4'b0000;
    assign bus.stall        = stall_s && !rst;
    assign bus.load_data    = load_data_q;
    assign bus.load_valid   = load_valid_q;
    assign bus.access_fault = fault_q;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the maximum number of REQ cycles to wait for dmem_ready (range 1..15).
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset; SHALL be synchronous and active-high.
REQ-004 mem_read_control  in  1  decoded load request.
REQ-005 mem_write_control  in  1  decoded store request.
REQ-006 funct3  in  3  access size and signedness (RV32I load/store encoding).
REQ-007 addr  in  32  effective byte address from the ALU.
REQ-008 store_data  in  32  rs2 value for stores.
REQ-009 dmem_req  out  1  memory request strobe.
REQ-010 dmem_we  out  1  1 = write, 0 = read.
REQ-011 dmem_addr  out  32  word address; SHALL be {addr[31:2], 2'b00}.
REQ-012 dmem_wdata  out  32  lane-replicated store data.
REQ-013 dmem_wstrb  out  4  byte enables; SHALL be 0 for reads.
REQ-014 dmem_ready  in  1  memory accepts/completes the request this cycle.
REQ-015 dmem_rdata  in  32  read word; valid when dmem_req && dmem_ready && !dmem_we.
REQ-016 stall  out  1  holds the pipeline while an access is in flight.
REQ-017 load_data  out  32  extended load result.
REQ-018 load_valid  out  1  one-cycle pulse; load_data is valid.
REQ-019 access_fault  out  1  one-cycle pulse flagging a misaligned, illegal or timed-out access.

Function
REQ-020 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-021 IDLE: if mem_write_control or mem_read_control is 1, the access SHALL be classified in the same cycle; mem_write_control SHALL take priority when both are set.
REQ-022 Illegal funct3 SHALL be defined as: loads 011, 110, 111; stores 011 through 111.
REQ-023 Misaligned SHALL be defined as: halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-024 Illegal or misaligned access: access_fault=1 next cycle, no dmem_req, stall=0, FSM stays IDLE.
REQ-025 Legal access: stall=1 combinationally in that IDLE cycle; addr, funct3, store_data and the direction SHALL be registered; next state REQ.
REQ-026 REQ: dmem_req=1 and stall=1; dmem outputs SHALL be driven from the registered values only, stable until the handshake.
REQ-027 The transfer SHALL complete on the first cycle with dmem_ready=1 in REQ; next state DONE.
REQ-028 A load SHALL register load_data on that same edge.
REQ-029 Timeout: a 4-bit counter SHALL clear on entry to REQ and increment each REQ cycle without dmem_ready.
REQ-030 When the counter reaches TIMEOUT without dmem_ready, access_fault=1 for one cycle and the FSM SHALL return to IDLE.
REQ-031 DONE: stall=0 and load_valid=1 for loads only; inputs SHALL be ignored; next state IDLE unconditionally. This lets the pipeline advance without re-issuing the access.
REQ-032 Store lanes: SB wstrb=0001<<addr[1:0], wdata={4{byte}}; SH wstrb=addr[1]?1100:0011, wdata={2{half}}; SW wstrb=1111, wdata=store_data.
REQ-033 Load extraction: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW passes the word through.
REQ-034 load_data SHALL hold its last value until the next completed load.
REQ-035 load_valid and access_fault SHALL never assert in the same cycle.

Reset
REQ-036 When rst=1 at an edge: FSM=IDLE, counter=0, load_data=0, load_valid=0, access_fault=0.
REQ-037 While rst=1: dmem_req=0, dmem_we=0, dmem_wstrb=0, stall=0.
REQ-038 rst asserted in REQ SHALL abandon the request with no fault pulse and no load_valid.

Verification
REQ-039 LB, addr=0x103, dmem_rdata=0x80FF_1234, ready on 2nd REQ cycle -> dmem_addr=0x100, load_data=0xFFFF_FF80, load_valid pulse, stall high for 3 cycles.
REQ-040 SH, addr=0x202, store_data=0x0000_ABCD, ready immediately -> wstrb=1100, wdata=0xABCD_ABCD, dmem_we=1, no load_valid.
REQ-041 LW, addr=0x101 -> access_fault pulse next cycle, no dmem_req, stall=0.
REQ-042 LHU with dmem_ready held 0, TIMEOUT=15 -> dmem_req high for 15 cycles, then access_fault pulse, FSM back to IDLE.
REQ-043 rst pulsed during REQ, then back-to-back LBU 0x3 (rdata 0x9900_0000) and SB -> no output from the aborted access; load_data=0x99; SB issued after DONE.
REQ-044 mem_read_control=mem_write_control=1, funct3=010, addr=0x40 -> a store is issued with wstrb=1111.
